// File: rtl/nlc_nch_horner.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// nlc_nch_horner -- multi-channel ADC linearizer: per-channel pending buffers,
// round-robin arbiter and one shared Horner polynomial engine.
// Optional macro NLC_SAT_EN: saturating reductions with a per-result sat flag.
// Rev 1.0
// =============================================================================
module nlc_nch_horner #(
    parameter int NCH   = 2,
    parameter int ORDER = 10,
    parameter int CW    = 40,
    parameter int FRAC  = 16,
    parameter int IDXW  = $clog2(ORDER + 3),
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int ADDRW = CHW + 2 + IDXW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      srdyi,
    input  logic [NCH*21-1:0]   x_adc,
    input  logic [19:0]         section_limit,
    input  logic                coef_we,
    input  logic [ADDRW-1:0]    coef_addr,
    input  logic [CW-1:0]       coef_wdata,
    output logic                srdyo,
    output logic [20:0]         x_lin,
    output logic [CHW-1:0]      ch_o,
    output logic [NCH-1:0]      ovf,
    output logic                sat
);

    localparam int PW = 2 * CW;

    typedef enum logic [2:0] {IDLE, SUB, NORM, HORN, OUT} state_t;

    // Reduce a full-width result to CW bits; MSB of the return is the saturation flag.
    function automatic logic [CW:0] red_cw(input logic signed [PW-1:0] v);
`ifdef NLC_SAT_EN
        logic signed [PW-1:0] mx;
        logic signed [PW-1:0] mn;
        mx = {{(PW-CW+1){1'b0}}, {(CW-1){1'b1}}};
        mn = ~mx;
        if (v > mx)      return {1'b1, mx[CW-1:0]};
        else if (v < mn) return {1'b1, mn[CW-1:0]};
        else             return {1'b0, v[CW-1:0]};
`else
        return {1'b0, v[CW-1:0]};
`endif
    endfunction

    function automatic logic [21:0] red21(input logic signed [CW-1:0] v);
`ifdef NLC_SAT_EN
        logic signed [CW-1:0] mx;
        logic signed [CW-1:0] mn;
        mx = {{(CW-20){1'b0}}, {20{1'b1}}};
        mn = ~mx;
        if (v > mx)      return {1'b1, mx[20:0]};
        else if (v < mn) return {1'b1, mn[20:0]};
        else             return {1'b0, v[20:0]};
`else
        return {1'b0, v[20:0]};
`endif
    endfunction

    // Lowest pending channel at or after ptr (with wrap); MSB = found.
    function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] p, input logic [CHW-1:0] ptr);
        logic [CHW:0] r;
        int           c;
        r = '0;
        for (int o = NCH - 1; o >= 0; o--) begin
            c = (int'(ptr) + o) % NCH;
            if (p[c]) r = {1'b1, CHW'(c)};
        end
        return r;
    endfunction

    logic signed [CW-1:0] bank_q [2**ADDRW];

    state_t                state_q, state_d;
    logic [NCH-1:0]        pend_q, pend_d;
    logic [NCH-1:0][20:0]  pdat_q, pdat_d;
    logic [NCH-1:0]        ovf_q, ovf_d;
    logic [CHW-1:0]        rr_q, rr_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [1:0]            sec_q, sec_d;
    logic signed [20:0]    x_q, x_d;
    logic signed [CW-1:0]  t_q, t_d;
    logic signed [CW-1:0]  xn_q, xn_d;
    logic signed [CW-1:0]  acc_q, acc_d;
    logic [IDXW-1:0]       k_q, k_d;
    logic                  satacc_q, satacc_d;
    logic                  srdyo_q, srdyo_d;
    logic                  sat_q, sat_d;
    logic [20:0]           x_lin_q, x_lin_d;
    logic [CHW-1:0]        ch_o_q, ch_o_d;

    logic [CHW:0]          w_pick;
    logic [CHW-1:0]        w_pick_ch;
    logic [20:0]           w_pick_x;
    logic [20:0]           w_mag;
    logic                  w_gt;
    logic                  w_pos;
    logic [1:0]            w_sec;
    logic [CHW-1:0]        w_rr_next;
    logic [IDXW-1:0]       w_rd_idx;
    logic signed [CW-1:0]  w_rd_a;
    logic signed [CW-1:0]  w_cord;

    logic                  consume;
    logic signed [PW-1:0]  prod;
    logic [CW:0]           rcw;
    logic [21:0]           r21;

    always_ff @(posedge clk) begin
        if (coef_we) bank_q[coef_addr] <= coef_wdata;
    end

    assign w_pick    = rr_pick(pend_q, rr_q);
    assign w_pick_ch = w_pick[CHW-1:0];
    assign w_pick_x  = pdat_q[w_pick_ch];
    assign w_mag     = w_pick_x[20] ? 21'(-w_pick_x) : w_pick_x;
    assign w_gt      = w_mag > {1'b0, section_limit};
    assign w_pos     = !w_pick_x[20] && (w_pick_x != '0);
    assign w_sec     = w_pos ? (w_gt ? 2'd3 : 2'd2) : (w_gt ? 2'd0 : 2'd1);
    assign w_rr_next = CHW'((int'(w_pick_ch) + 1) % NCH);

    // Bank is read in the cycle of use so writes reach in-flight computations.
    assign w_rd_idx = (state_q == SUB)  ? IDXW'(ORDER + 1) :
                      (state_q == NORM) ? IDXW'(ORDER + 2) : k_q;
    assign w_rd_a   = bank_q[{ch_q, sec_q, w_rd_idx}];
    assign w_cord   = bank_q[{ch_q, sec_q, IDXW'(ORDER)}];

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pdat_d   = pdat_q;
        ovf_d    = ovf_q;
        rr_d     = rr_q;
        ch_d     = ch_q;
        sec_d    = sec_q;
        x_d      = x_q;
        t_d      = t_q;
        xn_d     = xn_q;
        acc_d    = acc_q;
        k_d      = k_q;
        satacc_d = satacc_q;
        srdyo_d  = 1'b0;
        sat_d    = 1'b0;
        x_lin_d  = x_lin_q;
        ch_o_d   = ch_o_q;
        consume  = 1'b0;
        prod     = '0;
        rcw      = '0;
        r21      = '0;

        unique case (state_q)
            IDLE: begin
                if (w_pick[CHW]) begin
                    consume           = 1'b1;
                    pend_d[w_pick_ch] = 1'b0;
                    ch_d              = w_pick_ch;
                    x_d               = w_pick_x;
                    sec_d             = w_sec;
                    rr_d              = w_rr_next;
                    satacc_d          = 1'b0;
                    state_d           = SUB;
                end
            end
            SUB: begin
                prod     = (PW'(x_q) <<< FRAC) + PW'(w_rd_a);
                rcw      = red_cw(prod);
                t_d      = rcw[CW-1:0];
                satacc_d = satacc_q | rcw[CW];
                state_d  = NORM;
            end
            NORM: begin
                prod     = PW'(t_q) * PW'(w_rd_a);
                rcw      = red_cw(prod >>> FRAC);
                xn_d     = rcw[CW-1:0];
                satacc_d = satacc_q | rcw[CW];
                acc_d    = w_cord;
                k_d      = IDXW'(ORDER - 1);
                state_d  = (ORDER == 0) ? OUT : HORN;
            end
            HORN: begin
                prod     = PW'(acc_q) * PW'(xn_q);
                rcw      = red_cw((prod >>> FRAC) + PW'(w_rd_a));
                acc_d    = rcw[CW-1:0];
                satacc_d = satacc_q | rcw[CW];
                k_d      = k_q - IDXW'(1);
                if (k_q == '0) state_d = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result registers load on entry to OUT so they are valid during the OUT cycle.
        if (state_d == OUT) begin
            r21     = red21(acc_d >>> FRAC);
            x_lin_d = r21[20:0];
            sat_d   = satacc_d | r21[21];
            srdyo_d = 1'b1;
            ch_o_d  = ch_q;
        end

        for (int c = 0; c < NCH; c++) begin
            if (srdyi[c]) begin
                if (!pend_q[c] || (consume && (w_pick_ch == CHW'(c)))) begin
                    pend_d[c] = 1'b1;
                    pdat_d[c] = x_adc[21*c +: 21];
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            srdyo_q <= 1'b0;
            sat_q   <= 1'b0;
            x_lin_q <= '0;
            ch_o_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            srdyo_q <= srdyo_d;
            sat_q   <= sat_d;
            x_lin_q <= x_lin_d;
            ch_o_q  <= ch_o_d;
        end
        pdat_q   <= pdat_d;
        ch_q     <= ch_d;
        sec_q    <= sec_d;
        x_q      <= x_d;
        t_q      <= t_d;
        xn_q     <= xn_d;
        acc_q    <= acc_d;
        k_q      <= k_d;
        satacc_q <= satacc_d;
    end

    assign srdyo = srdyo_q;
    assign sat   = sat_q;
    assign x_lin = x_lin_q;
    assign ch_o  = ch_o_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nlc_nch_horner.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_nlc_nch_horner -- directed vectors with a scoreboard queue and monitor.
// Rev 1.0
// =============================================================================
module tb_nlc_nch_horner;

    localparam int NCH   = 2;
    localparam int CW    = 40;
    localparam int ADDRW = 7;
    localparam int LAT   = 14;  // srdyi cycle -> srdyo cycle when the engine is idle

`ifdef NLC_SAT_EN
    localparam int SAT_XL = 1048575;
    localparam int SAT_ST = 1;
`else
    localparam int SAT_XL = 0;
    localparam int SAT_ST = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    srdyi;
    logic [NCH*21-1:0] x_adc;
    logic [19:0]       section_limit;
    logic              coef_we;
    logic [ADDRW-1:0]  coef_addr;
    logic [CW-1:0]     coef_wdata;
    logic              srdyo;
    logic [20:0]       x_lin;
    logic [0:0]        ch_o;
    logic [NCH-1:0]    ovf;
    logic              sat;

    always #5 clk = ~clk;

    nlc_nch_horner dut (
        .clk           (clk),
        .reset         (reset),
        .srdyi         (srdyi),
        .x_adc         (x_adc),
        .section_limit (section_limit),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_wdata    (coef_wdata),
        .srdyo         (srdyo),
        .x_lin         (x_lin),
        .ch_o          (ch_o),
        .ovf           (ovf),
        .sat           (sat)
    );

    typedef struct {
        int ch;
        int xl;
        int st;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (srdyo) begin
            if (sb.size() == 0) begin
                chk("unexpected_srdyo", 1, 0);
            end else begin
                me = sb.pop_front();
                chk("x_lin",   longint'($signed(x_lin)), me.xl);
                chk("ch_o",    longint'(ch_o), me.ch);
                chk("sat",     longint'(sat), me.st);
                chk("latency", cyc, me.cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int sec, input int idx, input logic [CW-1:0] d);
        coef_we    = 1'b1;
        coef_addr  = {ch[0], sec[1:0], idx[3:0]};
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic push(input int ch, input int xl, input int st, input int c);
        exp_t e;
        e.ch  = ch;
        e.xl  = xl;
        e.st  = st;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic issue(input int ch, input int x);
        srdyi[ch]            = 1'b1;
        x_adc[21*ch +: 21]   = 21'(x);
        tick();
        srdyi                = '0;
    endtask

    task automatic issue_pair(input int x0, input int x1);
        srdyi          = 2'b11;
        x_adc[20:0]    = 21'(x0);
        x_adc[41:21]   = 21'(x1);
        tick();
        srdyi          = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int guard;
        int xs [5];
        int ys [5];

        reset         = 1'b1;
        srdyi         = '0;
        x_adc         = '0;
        section_limit = 20'd500;
        coef_we       = 1'b0;
        coef_addr     = '0;
        coef_wdata    = '0;
        tick(3);

        chk("rst_srdyo", longint'(srdyo), 0);
        chk("rst_x_lin", longint'(x_lin), 0);
        chk("rst_ch_o",  longint'(ch_o), 0);
        chk("rst_ovf",   longint'(ovf), 0);
        chk("rst_sat",   longint'(sat), 0);

        reset = 1'b0;
        tick();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++)
                for (int i = 0; i < 13; i++)
                    wr(c, s, i, '0);

        // Identity: x_lin = x through unit normalization and c1 = 1.0
        wr(0, 3, 12, 40'h10000);
        wr(0, 3, 1,  40'h10000);
        n0 = cyc;
        issue(0, 1000);
        push(0, 1000, 0, n0 + LAT);
        tick(15);

        // Section selection via per-section constant c0
        wr(0, 3, 1, '0);
        wr(0, 0, 0, 40'd1 << 16);
        wr(0, 1, 0, 40'd2 << 16);
        wr(0, 2, 0, 40'd3 << 16);
        wr(0, 3, 0, 40'd4 << 16);
        xs = '{600, 400, -400, -600, 0};
        ys = '{4, 3, 2, 1, 2};
        for (int i = 0; i < 5; i++) begin
            n0 = cyc;
            issue(0, xs[i]);
            push(0, ys[i], 0, n0 + LAT);
            tick(15);
        end

        // Arbitration: ch1 sample leaves the pointer at 0 before the first pair
        wr(1, 3, 0, 40'd7 << 16);
        wr(1, 0, 0, 40'd9 << 16);
        n0 = cyc;
        issue(1, 600);
        push(1, 7, 0, n0 + LAT);
        tick(15);
        n0 = cyc;
        issue_pair(600, 600);
        push(0, 4, 0, n0 + LAT);
        push(1, 7, 0, n0 + LAT + 14);
        tick(30);
        n0 = cyc;
        issue(0, 600);
        push(0, 4, 0, n0 + LAT);
        tick(15);
        n0 = cyc;
        issue_pair(600, 600);
        push(1, 7, 0, n0 + LAT);
        push(0, 4, 0, n0 + LAT + 14);
        tick(30);

        // Overflow: ch1 pending while engine busy; two further ch1 samples dropped
        chk("ovf_before", longint'(ovf), 0);
        n0 = cyc;
        issue(0, 600);
        push(0, 4, 0, n0 + LAT);
        tick();
        issue(1, 600);
        push(1, 7, 0, n0 + 28);
        tick();
        issue(1, -600);
        tick();
        issue(1, -600);
        chk("ovf_set", longint'(ovf), 2);
        tick(30);
        chk("ovf_sticky", longint'(ovf), 2);

        // Reset during HORN aborts the computation
        n0 = cyc;
        issue(0, 600);
        tick(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_srdyo", longint'(srdyo), 0);
        chk("mid_rst_x_lin", longint'(x_lin), 0);
        chk("mid_rst_ch_o",  longint'(ch_o), 0);
        chk("mid_rst_ovf",   longint'(ovf), 0);
        chk("mid_rst_sat",   longint'(sat), 0);
        tick(20);
        n0 = cyc;
        issue(0, 600);
        push(0, 4, 0, n0 + LAT);
        tick(15);

        // Saturation of the final 21-bit reduction
        wr(0, 3, 0, 40'h20_0000_0000);
        n0 = cyc;
        issue(0, 600);
        push(0, SAT_XL, SAT_ST, n0 + LAT);
        tick(15);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (sb.size() != 0) chk("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
